// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM state encodings,
// divider iteration count and the divide-by-zero LO value.
package mips_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS   = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Divider handshake bundle between the HI/LO sequencer and the divider.
// master: sequencer (drives start/operands); slave: divider (drives q/r/done).
interface hilo_div_if;

    logic        dv_start;
    logic        dv_signed;
    logic [31:0] dv_dividend;
    logic [31:0] dv_divisor;
    logic [31:0] dv_q;
    logic [31:0] dv_r;
    logic        dv_done;

    modport master (
        output dv_start,
        output dv_signed,
        output dv_dividend,
        output dv_divisor,
        input  dv_q,
        input  dv_r,
        input  dv_done
    );

    modport slave (
        input  dv_start,
        input  dv_signed,
        input  dv_dividend,
        input  dv_divisor,
        output dv_q,
        output dv_r,
        output dv_done
    );

endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and DIV/DIVU sequencer: latches operands, pulses the divider,
// stalls the CPU until done, commits q->LO and r->HI; handles MTHI/MTLO.
// Ports: clk, rst (sync, active-high); CPU side div_req/div_signed/rs_val/
// rt_val, mthi/mtlo/wdata, hi/lo, stall, div_done, timeout_err; divider side
// via hilo_div_if.master (dv_start/dv_signed/dv_dividend/dv_divisor/dv_q/
// dv_r/dv_done). Option macro DIV_ZERO_BYPASS_EN: divide-by-zero is resolved
// here in one cycle instead of going through the divider.
module hilo_div_ctrl
    import mips_div_pkg::*;
#(
    parameter int MAX_WAIT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_req,
    input  logic              div_signed,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [31:0]       wdata,
    hilo_div_if.master        dv,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              stall,
    output logic              div_done,
    output logic              timeout_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    div_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic          zero_bypass;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (rt_val == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    // A pending request stalls in the same cycle it is issued.
    assign stall = (state != S_IDLE) | div_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            hi             <= '0;
            lo             <= '0;
            div_done       <= 1'b0;
            timeout_err    <= 1'b0;
            dv.dv_start    <= 1'b0;
            dv.dv_signed   <= 1'b0;
            dv.dv_dividend <= '0;
            dv.dv_divisor  <= '0;
        end else begin
            dv.dv_start <= 1'b0;
            div_done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (div_req && zero_bypass) begin
                        lo       <= DIV_ZERO_LO;
                        hi       <= rs_val;
                        div_done <= 1'b1;
                    end else if (div_req) begin
                        dv.dv_signed   <= div_signed;
                        dv.dv_dividend <= rs_val;
                        dv.dv_divisor  <= rt_val;
                        dv.dv_start    <= 1'b1;
                        state          <= S_START;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // The divider still reports done in the first WAIT
                    // cycle, so done only counts once wait_cnt is non-zero.
                    if (wait_cnt != '0 && dv.dv_done) begin
                        lo       <= dv.dv_q;
                        hi       <= dv.dv_r;
                        div_done <= 1'b1;
                        state    <= S_IDLE;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed self-checking bench for hilo_div_ctrl with a behavioural
// 32-iteration divider model on the slave side of hilo_div_if.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, div_signed, mthi, mtlo;
    logic [31:0] rs_val, rt_val, wdata;
    logic [31:0] hi, lo;
    logic        stall, div_done, timeout_err;

    int checks = 0;
    int failures = 0;
    int starts = 0;

    always #5 clk = ~clk;

    hilo_div_if dv ();

    hilo_div_ctrl #(.MAX_WAIT(40)) dut (
        .clk(clk), .rst(rst),
        .div_req(div_req), .div_signed(div_signed),
        .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .dv(dv.master),
        .hi(hi), .lo(lo), .stall(stall),
        .div_done(div_done), .timeout_err(timeout_err)
    );

    // Divider model: done stays high one cycle after start (busy not yet
    // visible), then busy for 31 more cycles; done returns in cycle 34.
    logic        hold;
    logic        pend;
    logic [5:0]  busy;
    logic [31:0] mq, mr;

    function automatic logic [63:0] mdiv(input logic s,
                                         input logic [31:0] a, b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) return {32'($signed(a) % $signed(b)),
                       32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            busy <= '0;
            mq   <= '0;
            mr   <= '0;
        end else begin
            pend <= dv.dv_start;
            if (dv.dv_start)
                {mr, mq} <= mdiv(dv.dv_signed, dv.dv_dividend, dv.dv_divisor);
            if (pend) busy <= 6'd31;
            else if (busy != 0) busy <= busy - 6'd1;
        end
    end

    assign dv.dv_q    = mq;
    assign dv.dv_r    = mr;
    assign dv.dv_done = !hold && (busy == 0);

    always @(posedge clk) if (dv.dv_start === 1'b1) starts++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full divide through the divider: stall high cycles 0-34,
    // dv_start only in cycle 1, results and div_done in cycle 35.
    task automatic run_div(input string tag, input logic s,
                           input logic [31:0] a, b, eq, er);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        div_req = 1'b1; div_signed = s; rs_val = a; rt_val = b;
        #1;
        if (stall !== 1'b1) bad = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            div_req = 1'b0;
            #1;
            if (stall !== 1'b1) bad = 1'b1;
            if (dv.dv_start !== (c == 1)) bad = 1'b1;
        end
        @(negedge clk);
        #1;
        chk({tag, "_window"}, {31'd0, bad}, 32'd0);
        chk({tag, "_stall35"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done35"}, {31'd0, div_done}, 32'd1);
        chk({tag, "_lo"}, lo, eq);
        chk({tag, "_hi"}, hi, er);
        @(negedge clk);
        #1;
        chk({tag, "_done36"}, {31'd0, div_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic bad;
        int   s0;
        rst = 1'b1; hold = 1'b0;
        div_req = 1'b0; div_signed = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_val = '0; rt_val = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, div_done}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        chk("rst_start", {31'd0, dv.dv_start}, 32'd0);
        chk("rst_dvd", dv.dv_dividend, 32'd0);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF);

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h1;
        #1;
        chk("mt_both_hi", hi, 32'hA5A5_A5A5);
        chk("mt_both_lo", lo, 32'hA5A5_A5A5);
        @(negedge clk);
        mtlo = 1'b0;
        #1;
        chk("mtlo_lo", lo, 32'h1);
        chk("mtlo_hi", hi, 32'hA5A5_A5A5);

        // div_req with mthi in IDLE: divide wins; mthi in WAIT ignored.
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b0; rs_val = 32'd20; rt_val = 32'd6;
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        div_req = 1'b0; mthi = 1'b0;
        #1;
        chk("mt_vs_div_hi", hi, 32'hA5A5_A5A5);
        for (int c = 2; c <= 34; c++) begin
            @(negedge clk);
            mthi = (c == 5); wdata = 32'hDEAD_BEEF;
            if (c == 6) chk("mthi_wait_hi", hi, 32'hA5A5_A5A5);
        end
        mthi = 1'b0;
        @(negedge clk);
        #1;
        chk("div20_6_lo", lo, 32'd3);
        chk("div20_6_hi", hi, 32'd2);
        chk("div20_6_done", {31'd0, div_done}, 32'd1);

        // Reset in cycle 10 of a DIV.
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b1; rs_val = 32'hFFFF_FF9C; rt_val = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            div_req = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (div_done !== 1'b0 || stall !== 1'b0) bad = 1'b1;
        end
        chk("mid_rst_quiet", {31'd0, bad}, 32'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Divider never finishes: timeout after 40 WAIT cycles.
        hold = 1'b1;
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b0; rs_val = 32'd50; rt_val = 32'd5;
        bad = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            div_req = 1'b0;
            #1;
            if (stall !== 1'b1 || div_done !== 1'b0) bad = 1'b1;
        end
        chk("tmo_window", {31'd0, bad}, 32'd0);
        chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        chk("tmo_done", {31'd0, div_done}, 32'd0);
        chk("tmo_lo", lo, 32'd3);
        chk("tmo_hi", hi, 32'd0);
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

        // Divide by zero.
        s0 = starts;
`ifdef DIV_ZERO_BYPASS_EN
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b0; rs_val = 32'd5; rt_val = 32'd0;
        #1;
        chk("dz_stall0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        div_req = 1'b0;
        #1;
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'd5);
        chk("dz_done", {31'd0, div_done}, 32'd1);
        chk("dz_stall1", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("dz_no_start", 32'(starts - s0), 32'd0);
`else
        run_div("dz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        chk("dz_one_start", 32'(starts - s0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
